or_nor_sweep: RTL
=================

OR_NOR_SWEEP -- requirements
Module: or_nor_sweep

Interface
REQ-001 Parameter SETTLE, default 1, cycles each vector is held on x/y/key before r is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  one clock; reset is synchronous and active-high.
REQ-004 start  input  1  request one full sweep; sampled every cycle.
REQ-005 r  input  1  result returned by the downstream selectable OR/NOR stage (key=0 OR, key=1 NOR).
REQ-006 x  output  1  operand x driven to the stage.
REQ-007 y  output  1  operand y driven to the stage.
REQ-008 key  output  1  function select driven to the stage.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 table  output  8  captured r values; bit index = {key,x,y}.
REQ-012 pass  output  1  high when table equals expected 8'h1E; valid from done until the next accepted start.

Function
REQ-013 FSM states IDLE, DRIVE, SAMPLE, DONE; 3-bit vector index idx; 4-bit settle counter.
REQ-014 IDLE: start=1 -> DRIVE, idx=0, settle counter=0, table cleared to 8'h00, pass=0, busy=1.
REQ-015 start SHALL be ignored in every state except IDLE.
REQ-016 DRIVE and SAMPLE: {key,x,y} SHALL equal idx.
REQ-017 DRIVE: counter increments each cycle; after exactly SETTLE cycles in DRIVE -> SAMPLE.
REQ-018 SAMPLE (one cycle): table[idx] <= r at the closing edge; idx<7 -> DRIVE with idx+1 and counter cleared; idx=7 -> DONE.
REQ-019 Each vector occupies SETTLE+1 cycles; done SHALL be high in the cycle beginning exactly 8*(SETTLE+1) edges after the start-accepting edge.
REQ-020 DONE (one cycle): done=1, busy=0, pass=(table==8'h1E), {key,x,y}=3'b000; then -> IDLE.
REQ-021 idx SHALL NOT wrap past 7 within a sweep; the sweep always ends in DONE.
REQ-022 IDLE: x=y=key=0, busy=0, done=0; table and pass hold last sweep result.
REQ-023 start held high continuously SHALL produce back-to-back sweeps, the next one accepted in the IDLE cycle following DONE.

Reset
REQ-024 rst=1 at any edge, including mid-sweep: state=IDLE, idx=0, counter=0, x=y=key=0, busy=0, done=0, table=8'h00, pass=0.
REQ-025 rst has priority over start in the same cycle; no sweep is accepted while rst=1.

Structure
REQ-026 Shared package holds the state encoding, IDX_W=3, CNT_W=4, and EXPECTED_TABLE=8'h1E.
REQ-027 One sub-module, settle_timer (load/clear, count, terminal flag at SETTLE); everything else is in or_nor_sweep.
REQ-028 The bench instantiates the selectable OR/NOR stage downstream, wired x/y/key out -> stage, stage r -> r.

Verification
REQ-029 SETTLE=1, rst then start pulse -> busy for 16 cycles, done pulse 16 edges after acceptance, table=8'h1E, pass=1.
REQ-030 SETTLE=3, start -> {key,x,y} steps 0..7, each held 4 cycles; done 32 edges after acceptance.
REQ-031 Stage replaced by stuck-at-0 r -> table=8'h00, pass=0; stuck-at-1 -> table=8'hFF, pass=0.
REQ-032 rst asserted when idx=4 -> next cycle IDLE, all outputs 0, table=8'h00; a new start gives a full correct sweep.
REQ-033 start pulsed repeatedly during a sweep -> no restart, single done; start held high -> back-to-back sweeps with one IDLE cycle between done and the next DRIVE.

Source files
------------

// File: rtl/or_nor_sweep_pkg.sv
// Shared types and constants for the OR/NOR truth-table sweeper.
// Vector index is {key,x,y}; EXPECTED_TABLE is the good-stage truth table.
package or_nor_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam int IDX_W = 3;
   localparam int CNT_W = 4;
   localparam logic [7:0] EXPECTED_TABLE = 8'h1E;

endpackage

// File: rtl/or_nor_sweep_settle.sv
// Settle timer: counts cycles while enabled, flags the last settle cycle.
// clear has the same effect as reset and wins over en.
module settle_timer
   import or_nor_sweep_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic term
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // high during the SETTLE-th DRIVE cycle
   assign term = (cnt == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/or_nor_sweep.sv
// Walks {key,x,y} through all 8 vectors, samples the stage result into
// sweep_table and flags pass when it matches the OR/NOR truth table.
module or_nor_sweep
   import or_nor_sweep_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       r,
   output logic       x,
   output logic       y,
   output logic       key,
   output logic       busy,
   output logic       done,
   output logic [7:0] sweep_table,
   output logic       pass
);

   state_t           state;
   state_t           state_n;
   logic [IDX_W-1:0] idx;
   logic             term;
   logic             in_drive;
   logic             last_vec;
   logic [7:0]       table_n;

   assign in_drive = (state == ST_DRIVE);
   assign last_vec = (idx == IDX_W'(7));

   settle_timer #(
      .SETTLE(SETTLE)
   ) u_settle (
      .clk  (clk),
      .rst  (rst),
      .clear(!in_drive),
      .en   (in_drive),
      .term (term)
   );

   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE:   if (start) state_n = ST_DRIVE;
         ST_DRIVE:  if (term) state_n = ST_SAMPLE;
         ST_SAMPLE: state_n = last_vec ? ST_DONE : ST_DRIVE;
         ST_DONE:   state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   // table including this cycle's sample, so pass is valid with done
   always_comb begin
      table_n      = sweep_table;
      table_n[idx] = r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         sweep_table <= '0;
         pass        <= 1'b0;
      end else begin
         state <= state_n;
         if (state == ST_IDLE && start) begin
            idx         <= '0;
            sweep_table <= '0;
            pass        <= 1'b0;
         end else if (state == ST_SAMPLE) begin
            sweep_table <= table_n;
            if (last_vec) begin
               pass <= (table_n == EXPECTED_TABLE);
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

   always_comb begin
      {key, x, y} = '0;
      if (state == ST_DRIVE || state == ST_SAMPLE) begin
         {key, x, y} = idx;
      end
   end

   assign busy = (state == ST_DRIVE) || (state == ST_SAMPLE);
   assign done = (state == ST_DONE);

endmodule
